// File: rtl/bdev_arbiter.sv
// bdev_arbiter: shares one block-device port between N_CLIENTS requesters.
// Requests are arbitrated round-robin. Client tags are widened with the client
// index on the way down, and responses are routed back by that index. The
// write-data channel stays locked to the client that owns the current write
// burst until the burst completes.
// Optional: define BDEV_ARB_STATS_EN to add per-client request counters and a
// write-stall cycle counter.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1. A source holds valid and its payload
// stable until that edge, and never lowers valid without a transfer.
module bdev_arbiter #(
    parameter int N_CLIENTS        = 2,
    parameter int CLIENT_BITS      = 1,
    parameter int TAG_BITS         = 1,
    parameter int BEATS_PER_SECTOR = 64
) (
    input  logic                            clock,
    input  logic                            reset_n,
    // client request channels
    input  logic [N_CLIENTS-1:0]            cl_req_valid,
    output logic [N_CLIENTS-1:0]            cl_req_ready,
    input  logic [N_CLIENTS-1:0]            cl_req_bits_write,
    input  logic [32*N_CLIENTS-1:0]         cl_req_bits_offset,
    input  logic [32*N_CLIENTS-1:0]         cl_req_bits_len,
    input  logic [TAG_BITS*N_CLIENTS-1:0]   cl_req_bits_tag,
    // client write-data channels
    input  logic [N_CLIENTS-1:0]            cl_data_valid,
    output logic [N_CLIENTS-1:0]            cl_data_ready,
    input  logic [64*N_CLIENTS-1:0]         cl_data_bits_data,
    input  logic [TAG_BITS*N_CLIENTS-1:0]   cl_data_bits_tag,
    // client response channels
    output logic [N_CLIENTS-1:0]            cl_resp_valid,
    input  logic [N_CLIENTS-1:0]            cl_resp_ready,
    output logic [63:0]                     cl_resp_bits_data,
    output logic [TAG_BITS-1:0]             cl_resp_bits_tag,
    // device request channel
    output logic                            bdev_req_valid,
    input  logic                            bdev_req_ready,
    output logic                            bdev_req_bits_write,
    output logic [31:0]                     bdev_req_bits_offset,
    output logic [31:0]                     bdev_req_bits_len,
    output logic [TAG_BITS+CLIENT_BITS-1:0] bdev_req_bits_tag,
    // device write-data channel
    output logic                            bdev_data_valid,
    input  logic                            bdev_data_ready,
    output logic [63:0]                     bdev_data_bits_data,
    output logic [TAG_BITS+CLIENT_BITS-1:0] bdev_data_bits_tag,
    // device response channel
    input  logic                            bdev_resp_valid,
    output logic                            bdev_resp_ready,
    input  logic [63:0]                     bdev_resp_bits_data,
    input  logic [TAG_BITS+CLIENT_BITS-1:0] bdev_resp_bits_tag,
    // debug: 1 while a write burst owns the data channel
    output logic                            dbg_state_o
`ifdef BDEV_ARB_STATS_EN
    ,
    output logic [32*N_CLIENTS-1:0]         stat_req_count,
    output logic [31:0]                     stat_stall_cycles
`endif
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_WBURST = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CLIENT_BITS-1:0] rr_ptr_q;
    logic [CLIENT_BITS-1:0] rr_ptr_d;
    logic [CLIENT_BITS-1:0] lock_client_q;
    logic [37:0]            beat_cnt_q;

    logic [N_CLIENTS-1:0]   eligible;
    logic                   grant_found;
    logic [CLIENT_BITS-1:0] grant_idx;
    logic [CLIENT_BITS-1:0] cand_idx;
    logic                   req_fire;
    logic                   data_fire;
    logic                   wr_start;
    logic [37:0]            burst_beats;
    logic [CLIENT_BITS-1:0] resp_idx;
    logic                   resp_in_range;

    // Writes are masked while a burst owns the data channel; reads always compete.
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            eligible[i] = cl_req_valid[i] & ((state_q == S_IDLE) | ~cl_req_bits_write[i]);
        end
    end

    // Round-robin search: first eligible client at or after rr_ptr, modulo N_CLIENTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            cand_idx = CLIENT_BITS'((int'(rr_ptr_q) + k) % N_CLIENTS);
            if (!grant_found && eligible[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign rr_ptr_d = (grant_idx == CLIENT_BITS'(N_CLIENTS - 1)) ? '0
                                                                 : grant_idx + CLIENT_BITS'(1);

    // Request channel toward the device, fields muxed from the grantee.
    assign bdev_req_valid       = reset_n & grant_found;
    assign bdev_req_bits_write  = cl_req_bits_write[grant_idx];
    assign bdev_req_bits_offset = cl_req_bits_offset[32*grant_idx +: 32];
    assign bdev_req_bits_len    = cl_req_bits_len[32*grant_idx +: 32];
    assign bdev_req_bits_tag    = {grant_idx, cl_req_bits_tag[TAG_BITS*grant_idx +: TAG_BITS]};

    // Only the grantee sees ready, so a waiting client is never dropped.
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            cl_req_ready[i] = reset_n & bdev_req_ready & grant_found
                              & (grant_idx == CLIENT_BITS'(i));
        end
    end

    assign req_fire    = bdev_req_valid & bdev_req_ready;
    assign burst_beats = 38'(bdev_req_bits_len) * 38'(BEATS_PER_SECTOR);
    assign wr_start    = req_fire & bdev_req_bits_write & (bdev_req_bits_len != 32'd0);

    // Write-data channel follows the locked client, and only during a burst.
    assign bdev_data_valid     = reset_n & (state_q == S_WBURST) & cl_data_valid[lock_client_q];
    assign bdev_data_bits_data = cl_data_bits_data[64*lock_client_q +: 64];
    assign bdev_data_bits_tag  = {lock_client_q,
                                  cl_data_bits_tag[TAG_BITS*lock_client_q +: TAG_BITS]};
    assign data_fire           = bdev_data_valid & bdev_data_ready;

    // Data ready goes only to the locked client.
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            cl_data_ready[i] = reset_n & (state_q == S_WBURST) & bdev_data_ready
                               & (lock_client_q == CLIENT_BITS'(i));
        end
    end

    // Responses are routed by the index carried in the upper tag bits.
    assign resp_idx          = bdev_resp_bits_tag[TAG_BITS +: CLIENT_BITS];
    assign resp_in_range     = int'(resp_idx) < N_CLIENTS;
    assign cl_resp_bits_data = bdev_resp_bits_data;
    assign cl_resp_bits_tag  = bdev_resp_bits_tag[TAG_BITS-1:0];

    // Steer response valid to one client and take ready back from it; unknown indices are sunk.
    always_comb begin
        bdev_resp_ready = reset_n & ~resp_in_range;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cl_resp_valid[i] = reset_n & bdev_resp_valid & (resp_idx == CLIENT_BITS'(i));
            if (resp_idx == CLIENT_BITS'(i)) begin
                bdev_resp_ready = reset_n & cl_resp_ready[i];
            end
        end
    end

    // Arbiter pointer and IDLE/WBURST state machine.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            lock_client_q <= '0;
        end else begin
            if (req_fire) begin
                rr_ptr_q <= rr_ptr_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (wr_start) begin
                        lock_client_q <= grant_idx;
                        beat_cnt_q    <= burst_beats;
                        state_q       <= S_WBURST;
                    end
                end
                S_WBURST: begin
                    if (data_fire) begin
                        if (beat_cnt_q == 38'd1) begin
                            // A write accepted on the final beat chains straight into its burst.
                            if (wr_start) begin
                                lock_client_q <= grant_idx;
                                beat_cnt_q    <= burst_beats;
                            end else begin
                                beat_cnt_q <= '0;
                                state_q    <= S_IDLE;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 38'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dbg_state_o = (state_q == S_WBURST);

`ifdef BDEV_ARB_STATS_EN
    logic [31:0] stat_req_q [N_CLIENTS];
    logic [31:0] stat_stall_q;
    logic        write_masked;

    assign write_masked = (state_q == S_WBURST) & |(cl_req_valid & cl_req_bits_write);

    // Per-client accepted-request counters and masked-write stall counter, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                stat_req_q[i] <= '0;
            end
            stat_stall_q <= '0;
        end else begin
            if (req_fire) begin
                stat_req_q[grant_idx] <= stat_req_q[grant_idx] + 32'd1;
            end
            if (write_masked) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            stat_req_count[32*i +: 32] = stat_req_q[i];
        end
    end

    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_bdev_arbiter.sv
// Directed testbench for bdev_arbiter with two clients and 1-bit client tags.
module tb_bdev_arbiter;

    localparam int N  = 2;
    localparam int TB = 1;
    localparam int CB = 1;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [N-1:0]        cl_req_valid;
    logic [N-1:0]        cl_req_ready;
    logic [N-1:0]        cl_req_bits_write;
    logic [32*N-1:0]     cl_req_bits_offset;
    logic [32*N-1:0]     cl_req_bits_len;
    logic [TB*N-1:0]     cl_req_bits_tag;
    logic [N-1:0]        cl_data_valid;
    logic [N-1:0]        cl_data_ready;
    logic [64*N-1:0]     cl_data_bits_data;
    logic [TB*N-1:0]     cl_data_bits_tag;
    logic [N-1:0]        cl_resp_valid;
    logic [N-1:0]        cl_resp_ready;
    logic [63:0]         cl_resp_bits_data;
    logic [TB-1:0]       cl_resp_bits_tag;
    logic                bdev_req_valid;
    logic                bdev_req_ready;
    logic                bdev_req_bits_write;
    logic [31:0]         bdev_req_bits_offset;
    logic [31:0]         bdev_req_bits_len;
    logic [TB+CB-1:0]    bdev_req_bits_tag;
    logic                bdev_data_valid;
    logic                bdev_data_ready;
    logic [63:0]         bdev_data_bits_data;
    logic [TB+CB-1:0]    bdev_data_bits_tag;
    logic                bdev_resp_valid;
    logic                bdev_resp_ready;
    logic [63:0]         bdev_resp_bits_data;
    logic [TB+CB-1:0]    bdev_resp_bits_tag;
    logic                dbg_state_o;
`ifdef BDEV_ARB_STATS_EN
    logic [32*N-1:0]     stat_req_count;
    logic [31:0]         stat_stall_cycles;
`endif

    bdev_arbiter #(
        .N_CLIENTS(N), .CLIENT_BITS(CB), .TAG_BITS(TB), .BEATS_PER_SECTOR(64)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready),
        .cl_req_bits_write(cl_req_bits_write), .cl_req_bits_offset(cl_req_bits_offset),
        .cl_req_bits_len(cl_req_bits_len), .cl_req_bits_tag(cl_req_bits_tag),
        .cl_data_valid(cl_data_valid), .cl_data_ready(cl_data_ready),
        .cl_data_bits_data(cl_data_bits_data), .cl_data_bits_tag(cl_data_bits_tag),
        .cl_resp_valid(cl_resp_valid), .cl_resp_ready(cl_resp_ready),
        .cl_resp_bits_data(cl_resp_bits_data), .cl_resp_bits_tag(cl_resp_bits_tag),
        .bdev_req_valid(bdev_req_valid), .bdev_req_ready(bdev_req_ready),
        .bdev_req_bits_write(bdev_req_bits_write), .bdev_req_bits_offset(bdev_req_bits_offset),
        .bdev_req_bits_len(bdev_req_bits_len), .bdev_req_bits_tag(bdev_req_bits_tag),
        .bdev_data_valid(bdev_data_valid), .bdev_data_ready(bdev_data_ready),
        .bdev_data_bits_data(bdev_data_bits_data), .bdev_data_bits_tag(bdev_data_bits_tag),
        .bdev_resp_valid(bdev_resp_valid), .bdev_resp_ready(bdev_resp_ready),
        .bdev_resp_bits_data(bdev_resp_bits_data), .bdev_resp_bits_tag(bdev_resp_bits_tag),
        .dbg_state_o(dbg_state_o)
`ifdef BDEV_ARB_STATS_EN
        ,
        .stat_req_count(stat_req_count), .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Watchdog: the bench never waits on the DUT, but guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] rr_exp [4];
        logic       rdy;
        int         sent;

        rr_exp[0] = 2'b00; rr_exp[1] = 2'b11; rr_exp[2] = 2'b00; rr_exp[3] = 2'b11;

        // Reset with live-looking inputs: every ready/valid output must be 0.
        reset_n             = 1'b0;
        cl_req_valid        = 2'b11;
        cl_req_bits_write   = 2'b00;
        cl_req_bits_offset  = {32'h0000_0200, 32'h0000_0100};
        cl_req_bits_len     = {32'd1, 32'd1};
        cl_req_bits_tag     = 2'b10;
        cl_data_valid       = 2'b11;
        cl_data_bits_data   = '0;
        cl_data_bits_tag    = 2'b10;
        cl_resp_ready       = 2'b11;
        bdev_req_ready      = 1'b1;
        bdev_data_ready     = 1'b1;
        bdev_resp_valid     = 1'b1;
        bdev_resp_bits_data = 64'h0;
        bdev_resp_bits_tag  = 2'b00;
        #2;
        check("rst_req_valid", bdev_req_valid, 0);
        check("rst_cl_req_ready", cl_req_ready, 0);
        check("rst_data_valid", bdev_data_valid, 0);
        check("rst_cl_data_ready", cl_data_ready, 0);
        check("rst_cl_resp_valid", cl_resp_valid, 0);
        check("rst_resp_ready", bdev_resp_ready, 0);
        check("rst_state", dbg_state_o, 0);

        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        cl_data_valid   = 2'b00;
        bdev_resp_valid = 1'b0;
        #1;

        // Both clients hold reads: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            check("rr_tag", bdev_req_bits_tag, rr_exp[k]);
            check("rr_cl_ready", cl_req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_offset", bdev_req_bits_offset, (k % 2 == 0) ? 32'h100 : 32'h200);
            step();
        end

        // Client 1 writes 2 sectors at offset 0x10.
        cl_req_valid       = 2'b10;
        cl_req_bits_write  = 2'b10;
        cl_req_bits_offset = {32'h0000_0010, 32'h0000_0100};
        cl_req_bits_len    = {32'd2, 32'd1};
        #1;
        check("wr_req_valid", bdev_req_valid, 1);
        check("wr_req_write", bdev_req_bits_write, 1);
        check("wr_req_offset", bdev_req_bits_offset, 32'h10);
        check("wr_req_len", bdev_req_bits_len, 2);
        check("wr_req_tag", bdev_req_bits_tag, 2'b11);
        check("wr_cl_ready", cl_req_ready, 2'b10);
        check("wr_state_idle", dbg_state_o, 0);
        step();

        // 128-beat burst with periodic device back-pressure; client 0 data must never be taken.
        cl_req_valid      = 2'b00;
        cl_req_bits_write = 2'b00;
        cl_data_valid     = 2'b11;
        cl_data_bits_tag  = 2'b10;
        sent = 0;
        for (int cyc = 0; sent < 128; cyc++) begin
            rdy = ((cyc % 4) != 3);
            bdev_data_ready = rdy;
            cl_data_bits_data = {64'hA5A5_0000_0000_0000 | 64'(sent), 64'hDEAD_BEEF_0000_0000};
            if (exp_q.size() == 0) exp_q.push_back(64'hA5A5_0000_0000_0000 | 64'(sent));
            if (cyc >= 10 && cyc <= 12) begin
                cl_req_valid[0]      = 1'b1;
                cl_req_bits_write[0] = 1'b1;
                cl_req_bits_tag[0]   = 1'b0;
            end else if (cyc == 13) begin
                cl_req_valid[0]          = 1'b1;
                cl_req_bits_write[0]     = 1'b0;
                cl_req_bits_offset[31:0] = 32'h300;
            end else if (cyc >= 14 && cyc < 20) begin
                cl_req_valid[0] = 1'b0;
            end else if (cyc >= 20) begin
                cl_req_valid[0]       = 1'b1;
                cl_req_bits_write[0]  = 1'b1;
                cl_req_bits_len[31:0] = 32'd0;
            end
            #1;
            check("burst_state", dbg_state_o, 1);
            check("burst_data_valid", bdev_data_valid, 1);
            check("burst_data", bdev_data_bits_data, exp_q[0]);
            check("burst_tag", bdev_data_bits_tag, 2'b11);
            check("burst_cl_data_ready", cl_data_ready, {rdy, 1'b0});
            if ((cyc >= 10 && cyc <= 12) || cyc >= 20) begin
                check("burst_wr_masked", bdev_req_valid, 0);
                check("burst_wr_cl_ready", cl_req_ready, 0);
            end
            if (cyc == 13) begin
                check("burst_rd_valid", bdev_req_valid, 1);
                check("burst_rd_write", bdev_req_bits_write, 0);
                check("burst_rd_tag", bdev_req_bits_tag, 2'b00);
                check("burst_rd_cl_ready", cl_req_ready, 2'b01);
            end
            if (rdy) begin
                void'(exp_q.pop_front());
                sent++;
            end
            step();
        end

        // Burst over: data channel closed, stalled client 0 write (len 0) now granted.
        #1;
        check("post_state", dbg_state_o, 0);
        check("post_data_valid", bdev_data_valid, 0);
        check("post_cl_data_ready", cl_data_ready, 0);
        check("post_wr_valid", bdev_req_valid, 1);
        check("post_wr_write", bdev_req_bits_write, 1);
        check("post_wr_tag", bdev_req_bits_tag, 2'b00);
        check("post_wr_len", bdev_req_bits_len, 0);
        step();

        // Zero-length write left us in IDLE: client 1 write is granted right away.
        cl_req_valid           = 2'b10;
        cl_req_bits_write      = 2'b10;
        cl_req_bits_len[63:32] = 32'd1;
        cl_data_valid          = 2'b00;
        bdev_data_ready        = 1'b1;
        #1;
        check("len0_state", dbg_state_o, 0);
        check("len0_next_valid", bdev_req_valid, 1);
        check("len0_next_tag", bdev_req_bits_tag, 2'b11);
        check("len0_next_cl_ready", cl_req_ready, 2'b10);
        step();

        cl_req_valid      = 2'b00;
        cl_req_bits_write = 2'b00;
        cl_data_valid     = 2'b10;
        #1;
        check("b2_state", dbg_state_o, 1);
        // 36 beats; a client 0 read at beat 5 moves rr_ptr to 1.
        for (int b = 1; b <= 36; b++) begin
            cl_req_valid = (b == 5) ? 2'b01 : 2'b00;
            #1;
            if (b == 5) check("b2_rd_tag", bdev_req_bits_tag, 2'b00);
            step();
        end

        // Beat 37 offered; reset mid-cycle with both clients reading.
        cl_req_valid = 2'b11;
        #2;
        check("b2_before_rst_state", dbg_state_o, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_data_valid", bdev_data_valid, 0);
        check("midrst_cl_data_ready", cl_data_ready, 0);
        check("midrst_req_valid", bdev_req_valid, 0);
        check("midrst_cl_req_ready", cl_req_ready, 0);
        check("midrst_state", dbg_state_o, 0);
        step();
        #2 reset_n = 1'b1;
        #1;
        check("after_rst_state", dbg_state_o, 0);
        check("after_rst_data_valid", bdev_data_valid, 0);
        check("after_rst_first_tag", bdev_req_bits_tag, 2'b00);
        check("after_rst_cl_ready", cl_req_ready, 2'b01);
        step();
        #1;
        check("after_rst_second_tag", bdev_req_bits_tag, 2'b11);
        step();

        // Response routing by tag index.
        cl_req_valid        = 2'b00;
        bdev_resp_valid     = 1'b1;
        bdev_resp_bits_tag  = 2'b10;
        bdev_resp_bits_data = 64'h1111_2222_3333_4444;
        cl_resp_ready       = 2'b11;
        #1;
        check("resp1_valid", cl_resp_valid, 2'b10);
        check("resp1_tag", cl_resp_bits_tag, 0);
        check("resp1_data", cl_resp_bits_data, 64'h1111_2222_3333_4444);
        check("resp1_ready", bdev_resp_ready, 1);
        step();
        bdev_resp_bits_tag  = 2'b01;
        bdev_resp_bits_data = 64'h5555_6666_7777_8888;
        #1;
        check("resp0_valid", cl_resp_valid, 2'b01);
        check("resp0_tag", cl_resp_bits_tag, 1);
        check("resp0_data", cl_resp_bits_data, 64'h5555_6666_7777_8888);
        check("resp0_ready", bdev_resp_ready, 1);
        step();
        bdev_resp_bits_tag = 2'b10;
        cl_resp_ready      = 2'b01;
        #1;
        check("resp_bp_valid", cl_resp_valid, 2'b10);
        check("resp_bp_ready", bdev_resp_ready, 0);
        step();
        cl_resp_ready = 2'b11;
        #1;
        check("resp_bp_release", bdev_resp_ready, 1);
        step();
        bdev_resp_valid = 1'b0;
        #1;
        check("resp_idle_valid", cl_resp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bdev_arbiter.md
Name: bdev_arbiter

Overview:
- Shares one simulated block device port (req/data/resp channels, 64-bit data, 32-bit sector offset/len) between N_CLIENTS requesters.
- Request channel: round-robin arbitration. Client tags are widened with the client index on the way down, and responses are routed back by that index.
- Write data channel: locked to the client whose write request was granted until that write's data burst completes.
- Sits between the per-core block device clients and the single device model / block device controller.

Parameters:
- N_CLIENTS, 2, number of requesters (2..8).
- CLIENT_BITS, 1, clog2(N_CLIENTS); must be ≥1.
- TAG_BITS, 1, client-side tag width.
- BEATS_PER_SECTOR, 64, data beats per sector (512 B / 8 B).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- cl_req_valid  in  N_CLIENTS  per-client request valid.
- cl_req_ready  out  N_CLIENTS  per-client request ready.
- cl_req_bits_write  in  N_CLIENTS  per-client write flag.
- cl_req_bits_offset  in  32*N_CLIENTS  packed sector offsets, client i at [32i+31:32i].
- cl_req_bits_len  in  32*N_CLIENTS  packed sector counts.
- cl_req_bits_tag  in  TAG_BITS*N_CLIENTS  packed client tags.
- cl_data_valid  in  N_CLIENTS  per-client write-data valid.
- cl_data_ready  out  N_CLIENTS  per-client write-data ready.
- cl_data_bits_data  in  64*N_CLIENTS  packed write data.
- cl_data_bits_tag  in  TAG_BITS*N_CLIENTS  packed write-data tags.
- cl_resp_valid  out  N_CLIENTS  per-client response valid.
- cl_resp_ready  in  N_CLIENTS  per-client response ready.
- cl_resp_bits_data  out  64  response data, shared by all clients.
- cl_resp_bits_tag  out  TAG_BITS  response tag with the client index stripped.
- bdev_req_valid/ready/bits_write/bits_offset[31:0]/bits_len[31:0]/bits_tag[TAG_BITS+CLIENT_BITS-1:0]  out/in/out/out/out/out  device request channel.
- bdev_data_valid/ready/bits_data[63:0]/bits_tag[TAG_BITS+CLIENT_BITS-1:0]  out/in/out/out  device write-data channel.
- bdev_resp_valid/ready/bits_data[63:0]/bits_tag[TAG_BITS+CLIENT_BITS-1:0]  in/out/in/in  device response channel.

Behaviour:
- Reset (async assert, sync deassert):
  - rr_ptr=0, state=IDLE, beat_cnt=0, lock_client=0.
  - All ready/valid outputs are 0 while reset_n=0.
- Request arbitration (combinational grant, registered pointer):
  - Grant goes to the first valid client at or after rr_ptr, searching modulo N_CLIENTS.
  - bdev_req_valid = |eligible valids. Fields are muxed from the grantee.
  - bdev_req_bits_tag = {grantee index, client tag}.
  - cl_req_ready[g] = bdev_req_ready & grant[g]. A valid client is never dropped.
  - On each handshake, rr_ptr <= grantee+1 (wraps N_CLIENTS-1 -> 0).
  - No handshake: rr_ptr unchanged. Grant may change between cycles if valids change; clients obey ready/valid.
- State machine IDLE / WBURST:
  - IDLE: all requests eligible.
    - Accepted write with len>0: lock_client <= grantee, beat_cnt <= len*BEATS_PER_SECTOR (38-bit arithmetic, no overflow), go to WBURST.
    - Accepted write with len=0: no burst, stay in IDLE.
    - Reads: no state change.
  - WBURST: only read requests are eligible. Write requests are masked from arbitration and stall; reads from any client proceed.
    - Data channel: bdev_data_* muxed from lock_client, tag prefixed with lock_client.
    - cl_data_ready[lock_client] = bdev_data_ready. Every other cl_data_ready = 0.
    - Each data handshake: beat_cnt--. Handshake at beat_cnt==1 -> IDLE in the next cycle.
  - IDLE: bdev_data_valid=0, all cl_data_ready=0. Data offered before its request is granted stalls.
- Response routing:
  - idx = bdev_resp_bits_tag[TAG_BITS+CLIENT_BITS-1:TAG_BITS].
  - cl_resp_valid[idx] = bdev_resp_valid; bdev_resp_ready = cl_resp_ready[idx]; data/tag pass through.
  - idx ≥ N_CLIENTS: response is sunk (ready=1, no client valid).
  - Zero-latency, independent of state.
- Simultaneous events: a request grant, a data beat and a response may all complete in the same cycle.
  - A write accepted in the cycle WBURST ends is legal; the transition is straight to a new WBURST.
- Reset mid-burst: burst abandoned, returns to IDLE. The device side is reset together.

Optional Feature:
- BDEV_ARB_STATS_EN defined:
  - Adds output stat_req_count [32*N_CLIENTS]: per-client accepted-request counters, 32-bit wrap, cleared by reset.
  - Adds output stat_stall_cycles [32]: counts cycles where some client's write is masked in WBURST.
- Undefined: ports absent, no counters.

Test Plan:
- Clients 0 and 1 both hold read requests (tags 0/1) continuously, bdev_req_ready=1 -> grants alternate 0,1,0,1; bdev_req_bits_tag = 2'b00, 2'b11, 2'b00, 2'b11.
- Client 1 writes len=2 at offset 0x10 -> lock_client=1, exactly 128 data beats forwarded with tag {1,t}; client 0 data ready stays 0; IDLE after beat 128.
- During the client 1 burst, client 0 issues a write and then a read -> write stalls until the burst ends, read is granted immediately.
- Device responses with tags 2'b10 then 2'b01 -> cl_resp_valid=2'b10 (tag 0), then 2'b01 (tag 1). With cl_resp_ready[1]=0, bdev_resp_ready=0 until it rises.
- Write len=0 -> no WBURST entry, next write is granted the following cycle.
- Assert reset_n=0 at beat 37 of a burst -> all outputs 0 asynchronously; after release, state IDLE, rr_ptr=0, client 0 granted first.
